// File: rtl/imem_loader.sv
// Serial instruction-memory loader: shifts in 32-bit words MSB first, then
// issues them one per SLOT-cycle slot with a one-cycle valid pulse.
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int SLOT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        in_last,
    output logic        ready,
    output logic [5:0]  wr_count,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        done,
    output logic        err
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0]  DEPTH_W = 6'(DEPTH);
    localparam logic [1:0]  PH_LAST = 2'(SLOT - 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] sh_q, sh_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  wr_count_q, wr_count_d;
    logic [5:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  phase_q, phase_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        wr_en_s;
    logic [31:0] wr_data_s;

    logic [31:0] mem [DEPTH];

    assign wr_data_s = {sh_q[30:0], in_bit};

    // Next-state and output decode for the load/run/done/err sequencer.
    always_comb begin
        state_d       = state_q;
        sh_d          = sh_q;
        bit_cnt_d     = bit_cnt_q;
        wr_count_d    = wr_count_q;
        rd_ptr_d      = rd_ptr_q;
        phase_d       = phase_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        wr_en_s       = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    if (wr_count_q == DEPTH_W) begin
                        state_d = S_ERR;
                    end else begin
                        sh_d = wr_data_s;
                        if (bit_cnt_q == 5'd31) begin
                            wr_en_s    = 1'b1;
                            wr_count_d = wr_count_q + 6'd1;
                            bit_cnt_d  = 5'd0;
                            if (in_last) begin
                                state_d  = S_RUN;
                                phase_d  = 2'd0;
                                rd_ptr_d = 6'd0;
                            end else begin
                                state_d = S_LOAD;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            if (in_last) begin
                                state_d = S_ERR;
                            end else begin
                                state_d = S_LOAD;
                            end
                        end
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                if (phase_q == 2'd0) begin
                    instr_d       = mem[rd_ptr_q[AW-1:0]];
                    rd_ptr_d      = rd_ptr_q + 6'd1;
                    instr_valid_d = 1'b1;
                end else begin
                    instr_valid_d = 1'b0;
                end
                // rd_ptr has already advanced past the slot's word by its last phase.
                if (phase_q == PH_LAST) begin
                    phase_d = 2'd0;
                    if (rd_ptr_q == wr_count_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
        ready_d = (state_d == S_LOAD);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_LOAD;
            sh_q          <= 32'd0;
            bit_cnt_q     <= 5'd0;
            wr_count_q    <= 6'd0;
            rd_ptr_q      <= 6'd0;
            phase_q       <= 2'd0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            bit_cnt_q     <= bit_cnt_d;
            wr_count_q    <= wr_count_d;
            rd_ptr_q      <= rd_ptr_d;
            phase_q       <= phase_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Program storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_count_q[AW-1:0]] <= wr_data_s;
        end
    end

    assign ready       = ready_q;
    assign wr_count    = wr_count_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, 32, number of 32-bit instruction words stored.
REQ-002 Parameter SLOT, 4, cycles per issued instruction; matches the decoder's 4-cycle cadence.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_bit is valid this cycle.
REQ-006 in_bit  input  1  serial program bit; each word is sent MSB first (bit 31 first), matching the "%b" text image order.
REQ-007 in_last  input  1  qualifies the final bit of the final word; sampled only when in_valid=1.
REQ-008 ready  output  1  high in LOAD; bits are accepted only when in_valid=1 and ready=1.
REQ-009 wr_count  output  6  number of complete words written, range 0..DEPTH.
REQ-010 instr  output  32  currently issued instruction word.
REQ-011 instr_valid  output  1  one-cycle pulse marking a newly issued instr.
REQ-012 done  output  1  high once the whole program has been issued.
REQ-013 err  output  1  high on a framing or overflow error.

Function
REQ-014 The FSM SHALL have four states: LOAD, RUN, DONE and ERR.
REQ-015 In LOAD, each accepted bit SHALL shift into a 32-bit register, {sh[30:0], in_bit}, and increment a 5-bit bit counter.
REQ-016 On an accepted bit with bit counter 31, the completed word SHALL be written to mem[wr_count]; wr_count then increments and the bit counter wraps to 0.
REQ-017 When in_last=1 is accepted with bit counter 31, the word SHALL be written and the FSM SHALL enter RUN next cycle (cycle E).
REQ-018 When in_last=1 is accepted with bit counter not 31 (partial word), nothing SHALL be written and the FSM SHALL go to ERR.
REQ-019 When an accepted bit arrives with wr_count=DEPTH (overflow), it SHALL be discarded and the FSM SHALL go to ERR.
REQ-020 When in_valid=0, shift register and counters SHALL hold; gaps between bits are allowed.
REQ-021 In RUN, a 2-bit phase counter SHALL start at 0 in cycle E and wrap from SLOT-1 to 0.
REQ-022 At phase 0, instr SHALL load mem[rd_ptr], rd_ptr SHALL increment, and instr_valid SHALL be registered high.
- Word k is visible with instr_valid=1 at cycle E+1+4k.
- instr holds its value between pulses.
REQ-023 After phase 3 of the slot that issued word wr_count-1, the FSM SHALL enter DONE at cycle E+4N, where N=wr_count.
REQ-024 In DONE, done SHALL be 1, instr SHALL keep the last word, and the FSM SHALL stay until reset.
REQ-025 In ERR, err SHALL be 1, instr_valid SHALL be 0, and the FSM SHALL stay until reset; wr_count freezes.
REQ-026 ready SHALL be 1 only in LOAD; in_valid in any other state SHALL be ignored with no effect.
REQ-027 Memory contents SHALL NOT be cleared by reset; only words written since reset are ever issued.

Reset
REQ-028 rst_n=0 SHALL immediately force: state LOAD, ready=1, wr_count=0, instr=0, instr_valid=0, done=0, err=0, and all internal counters and pointers to 0.
REQ-029 Reset asserted mid-load or mid-run SHALL abort the operation; after release, loading restarts at word 0.
REQ-030 Deassertion SHALL be synchronous to clk; the first bit can be accepted on the first rising edge after release.

Verification
REQ-031 Load 0x00500093 then 0x00308113 (in_last on the 64th bit) -> wr_count=2; instr_valid at E+1 with 0x00500093 and at E+5 with 0x00308113; done=1 from E+8.
REQ-032 Load one word with in_valid toggling 1,0,1,0 -> same word is issued as with continuous in_valid; the gaps have no effect.
REQ-033 Assert in_last on the 20th bit -> err=1 next cycle, wr_count=0, ready=0, no instr_valid pulse.
REQ-034 Load 32 words without in_last, then 1 extra bit -> err=1, wr_count=32.
REQ-035 Pulse rst_n low during RUN after 1 of 3 words issued -> all outputs return to reset values asynchronously; a new 1-word load then issues correctly from mem[0].
REQ-036 in_valid=1 held during RUN and DONE -> wr_count is unchanged and the issue sequence is unaffected.
